// File: rtl/vv_mac_engine.sv
// vv_mac_engine: vector-vector engine with host-loadable operand BRAMs A/B and
// a result BRAM. Runtime element-wise multiply (mode 0) or dot product (mode 1).
// Optional macro VV_RELU_EN: with SIGNED=1, results with MSB set are written as 0.
module vv_mac_engine #(
   parameter int unsigned DW         = 8,
   parameter int unsigned N          = 4,
   parameter int unsigned BRAM_DEPTH = 32,
   parameter int unsigned SIGNED     = 0,
   parameter int unsigned AW         = $clog2(BRAM_DEPTH),
   parameter int unsigned RW         = 2*DW + $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic [AW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic [RW-1:0] dot_out,
   input  logic [AW-1:0] rom_vec_a_wr_addr,
   input  logic [DW-1:0] rom_vec_a_wr_data,
   input  logic          rom_vec_a_wr_we,
   input  logic [AW-1:0] rom_vec_b_wr_addr,
   input  logic [DW-1:0] rom_vec_b_wr_data,
   input  logic          rom_vec_b_wr_we,
   input  logic [AW-1:0] ram_rd_addr,
   output logic [RW-1:0] ram_rd_data
);

   localparam int unsigned PW = 2*DW;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [DW-1:0] mem_a [BRAM_DEPTH];
   logic [DW-1:0] mem_b [BRAM_DEPTH];
   logic [RW-1:0] mem_r [BRAM_DEPTH];

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          drain_q, drain_d;
   logic [AW-1:0] len_q, len_d;
   logic          mode_q, mode_d;
   logic [RW-1:0] acc_q, acc_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [RW-1:0] dot_q, dot_d;
   logic [RW-1:0] rd_data_q;

   logic [DW-1:0] a_rd_q, b_rd_q;
   logic          v1_q, v2_q;
   logic [AW-1:0] idx1_q, idx2_q;
   logic [RW-1:0] prod_q;

   logic signed [PW-1:0] a_s, b_s, prod_s;
   logic [PW-1:0]        a_u, b_u, prod_u;
   logic [RW-1:0]        prod_c;
   logic [AW-1:0]        len_clamp_c;
   logic                 res_we_c;
   logic [AW-1:0]        res_addr_c;
   logic [RW-1:0]        res_wdata_c;

   // Negative results forced to zero when the rectifier is built in
   function automatic logic [RW-1:0] relu(input logic [RW-1:0] x);
`ifdef VV_RELU_EN
      if ((SIGNED != 0) && x[RW-1]) relu = '0;
      else                          relu = x;
`else
      relu = x;
`endif
   endfunction

   // Product of the BRAM read data, extended to accumulator width
   always_comb begin
      a_s    = PW'($signed(a_rd_q));
      b_s    = PW'($signed(b_rd_q));
      prod_s = a_s * b_s;
      a_u    = PW'(a_rd_q);
      b_u    = PW'(b_rd_q);
      prod_u = a_u * b_u;
      if (SIGNED != 0) prod_c = RW'(prod_s);
      else             prod_c = RW'(prod_u);
   end

   assign len_clamp_c = (len > AW'(N)) ? AW'(N) : len;

   // Next-state, accumulator and result-write control
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      drain_d     = drain_q;
      len_d       = len_q;
      mode_d      = mode_q;
      acc_d       = acc_q;
      dot_d       = dot_q;
      res_we_c    = 1'b0;
      res_addr_c  = idx2_q;
      res_wdata_c = relu(prod_q);

      if (v2_q) begin
         acc_d = acc_q + prod_q;
         if (!mode_q) res_we_c = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = len_clamp_c;
               mode_d  = mode;
               acc_d   = '0;
               cnt_d   = '0;
               drain_d = 1'b0;
               state_d = (len_clamp_c == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == len_q - AW'(1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) begin
               state_d = S_DONE;
               // Last product enters the sum this cycle; publish it with done
               if (mode_q) begin
                  res_we_c    = 1'b1;
                  res_addr_c  = '0;
                  res_wdata_c = relu(acc_d);
                  dot_d       = relu(acc_d);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // Control state, pipeline valids, outputs and registered result read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         drain_q   <= 1'b0;
         len_q     <= '0;
         mode_q    <= 1'b0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dot_q     <= '0;
         rd_data_q <= '0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         idx1_q    <= '0;
         idx2_q    <= '0;
         prod_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         drain_q   <= drain_d;
         len_q     <= len_d;
         mode_q    <= mode_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dot_q     <= dot_d;
         rd_data_q <= mem_r[ram_rd_addr];
         v1_q      <= (state_q == S_RUN);
         v2_q      <= v1_q;
         idx1_q    <= cnt_q;
         idx2_q    <= idx1_q;
         prod_q    <= prod_c;
      end
   end

   // BRAM arrays: host writes (blocked while busy), operand reads, result writes
   always_ff @(posedge clk) begin
      if (rom_vec_a_wr_we && !busy_q) mem_a[rom_vec_a_wr_addr] <= rom_vec_a_wr_data;
      if (rom_vec_b_wr_we && !busy_q) mem_b[rom_vec_b_wr_addr] <= rom_vec_b_wr_data;
      a_rd_q <= mem_a[cnt_q];
      b_rd_q <= mem_b[cnt_q];
      if (res_we_c) mem_r[res_addr_c] <= res_wdata_c;
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign dot_out     = dot_q;
   assign ram_rd_data = rd_data_q;

endmodule

// File: tb/tb_vv_mac_engine.sv
// Directed bench for vv_mac_engine: unsigned and signed instances share stimulus.
module tb_vv_mac_engine;

   localparam int unsigned DW = 8;
   localparam int unsigned N  = 4;
   localparam int unsigned BD = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned RW = 18;
`ifdef VV_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start, mode;
   logic [AW-1:0] len;
   logic [AW-1:0] a_addr, b_addr, rd_addr;
   logic [DW-1:0] a_data, b_data;
   logic          a_we, b_we;
   logic          busy_u, done_u, busy_s, done_s;
   logic [RW-1:0] dot_u, rdat_u, dot_s, rdat_s;

   int errors = 0;
   int checks = 0;
   int dc, bc, np;

   always #5 clk = ~clk;

   vv_mac_engine #(.DW(DW), .N(N), .BRAM_DEPTH(BD), .SIGNED(0)) u_dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
      .busy(busy_u), .done(done_u), .dot_out(dot_u),
      .rom_vec_a_wr_addr(a_addr), .rom_vec_a_wr_data(a_data), .rom_vec_a_wr_we(a_we),
      .rom_vec_b_wr_addr(b_addr), .rom_vec_b_wr_data(b_data), .rom_vec_b_wr_we(b_we),
      .ram_rd_addr(rd_addr), .ram_rd_data(rdat_u));

   vv_mac_engine #(.DW(DW), .N(N), .BRAM_DEPTH(BD), .SIGNED(1)) u_sdut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
      .busy(busy_s), .done(done_s), .dot_out(dot_s),
      .rom_vec_a_wr_addr(a_addr), .rom_vec_a_wr_data(a_data), .rom_vec_a_wr_we(a_we),
      .rom_vec_b_wr_addr(b_addr), .rom_vec_b_wr_data(b_data), .rom_vec_b_wr_we(b_we),
      .ram_rd_addr(rd_addr), .ram_rd_data(rdat_s));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] addr, input logic [DW-1:0] av, input logic [DW-1:0] bv);
      a_addr = addr; a_data = av; a_we = 1'b1;
      b_addr = addr; b_data = bv; b_we = 1'b1;
      step();
      a_we = 1'b0; b_we = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] addr);
      rd_addr = addr;
      step();
   endtask

   // Start a run and observe 16 cycles; k counts cycles after the start edge
   task automatic run(input logic m, input logic [AW-1:0] l, input bit disturb,
                      output int dcyc, output int bcyc, output int npul);
      mode = m; len = l; start = 1'b1;
      step();
      start = 1'b0;
      dcyc = -1; bcyc = 0; npul = 0;
      for (int k = 1; k <= 16; k++) begin
         if (busy_u) bcyc++;
         if (done_u) begin
            npul++;
            if (dcyc < 0) dcyc = k;
         end
         if (disturb && k == 2) begin
            start = 1'b1; a_we = 1'b1; a_addr = '0; a_data = 8'd99;
         end
         if (disturb && k == 3) begin
            start = 1'b0; a_we = 1'b0;
         end
         step();
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; len = '0;
      a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; a_we = 1'b0; b_we = 1'b0;
      rd_addr = '0;
      step(); step();
      chk("rst_busy", 32'(busy_u), 32'd0);
      chk("rst_done", 32'(done_u), 32'd0);
      chk("rst_dot", 32'(dot_u), 32'd0);
      chk("rst_rdat", 32'(rdat_u), 32'd0);
      rst = 1'b0;
      step();

      // Element-wise, len 4
      load(5'd0, 8'd1, 8'd5); load(5'd1, 8'd2, 8'd6);
      load(5'd2, 8'd3, 8'd7); load(5'd3, 8'd4, 8'd8);
      run(1'b0, 5'd4, 1'b0, dc, bc, np);
      chk("ew_done_cycle", 32'(dc), 32'd7);
      chk("ew_busy_cycles", 32'(bc), 32'd7);
      chk("ew_done_pulses", 32'(np), 32'd1);
      rd(5'd0); chk("ew_res0", 32'(rdat_u), 32'd5);
      rd(5'd1); chk("ew_res1", 32'(rdat_u), 32'd12);
      rd(5'd2); chk("ew_res2", 32'(rdat_u), 32'd21);
      rd(5'd3); chk("ew_res3", 32'(rdat_u), 32'd32);

      // Dot product, same data
      run(1'b1, 5'd4, 1'b0, dc, bc, np);
      chk("dot_done_cycle", 32'(dc), 32'd7);
      chk("dot_out", 32'(dot_u), 32'd70);
      chk("dot_out_signed_inst", 32'(dot_s), 32'd70);
      rd(5'd0); chk("dot_res0", 32'(rdat_u), 32'd70);
      rd(5'd1); chk("dot_res1_kept", 32'(rdat_u), 32'd12);
      rd(5'd3); chk("dot_res3_kept", 32'(rdat_u), 32'd32);

      // Full-scale operands: 4*255*255
      for (int i = 0; i < 4; i++) load(AW'(i), 8'd255, 8'd255);
      run(1'b1, 5'd4, 1'b0, dc, bc, np);
      chk("dot_max", 32'(dot_u), 32'd260100);
      chk("dot_max_signed", 32'(dot_s), 32'd4);

      // len 0: immediate done, nothing written
      run(1'b1, 5'd0, 1'b0, dc, bc, np);
      chk("len0_done_cycle", 32'(dc), 32'd1);
      chk("len0_busy_cycles", 32'(bc), 32'd1);
      rd(5'd0); chk("len0_res0_kept", 32'(rdat_u), 32'd260100);

      // len 7 clamps to 4
      run(1'b0, 5'd7, 1'b0, dc, bc, np);
      chk("len7_done_cycle", 32'(dc), 32'd7);
      rd(5'd0); chk("len7_res0", 32'(rdat_u), 32'd65025);
      rd(5'd3); chk("len7_res3", 32'(rdat_u), 32'd65025);

      // Signed operands: A={-3,2}, B={5,1}
      load(5'd0, 8'd253, 8'd5); load(5'd1, 8'd2, 8'd1);
      run(1'b1, 5'd2, 1'b0, dc, bc, np);
      chk("sdot_done_cycle", 32'(dc), 32'd5);
      chk("sdot_out", 32'(dot_s), RELU ? 32'd0 : 32'd262131);
      chk("sdot_unsigned_inst", 32'(dot_u), 32'd1267);
      rd(5'd0); chk("sdot_res0", 32'(rdat_s), RELU ? 32'd0 : 32'd262131);
      run(1'b0, 5'd2, 1'b0, dc, bc, np);
      rd(5'd0);
      chk("sew_res0_signed", 32'(rdat_s), RELU ? 32'd0 : 32'd262129);
      chk("sew_res0_unsigned", 32'(rdat_u), 32'd1265);
      rd(5'd1); chk("sew_res1", 32'(rdat_u), 32'd2);
      rd(5'd2); chk("sew_res2_untouched", 32'(rdat_u), 32'd65025);

      // Start and A write while busy are ignored
      load(5'd0, 8'd1, 8'd5); load(5'd1, 8'd2, 8'd6);
      load(5'd2, 8'd3, 8'd7); load(5'd3, 8'd4, 8'd8);
      run(1'b0, 5'd4, 1'b1, dc, bc, np);
      chk("busy_start_pulses", 32'(np), 32'd1);
      chk("busy_start_done_cycle", 32'(dc), 32'd7);
      run(1'b0, 5'd1, 1'b0, dc, bc, np);
      rd(5'd0); chk("busy_write_dropped", 32'(rdat_u), 32'd5);
      rd(5'd1); chk("busy_res1", 32'(rdat_u), 32'd12);

      // Reset in second RUN cycle, then a clean run
      mode = 1'b1; len = 5'd4; start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("pre_rst_busy", 32'(busy_u), 32'd1);
      rst = 1'b1;
      step();
      chk("midrst_busy", 32'(busy_u), 32'd0);
      chk("midrst_done", 32'(done_u), 32'd0);
      chk("midrst_dot", 32'(dot_u), 32'd0);
      rst = 1'b0;
      step();
      run(1'b1, 5'd4, 1'b0, dc, bc, np);
      chk("post_rst_done_cycle", 32'(dc), 32'd7);
      chk("post_rst_dot", 32'(dot_u), 32'd70);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
